// File: rtl/fpu_pkg.sv
// Shared single-precision FPU constants, field positions and converter
// state encodings, common to the float/int converter pair.
package fpu_pkg;

    localparam int SIGN_POS = 31;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 23;
    localparam int MANT_HI  = 22;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;

    localparam logic [9:0]  BIAS_SP    = 10'd127;
    localparam logic [7:0]  EXP_SP_MAX = 8'hFF;
    localparam logic [31:0] INT32_MIN  = 32'h80000000;

    typedef enum logic [2:0] {
        GET_A         = 3'd0,
        UNPACK        = 3'd1,
        SPECIAL_CASES = 3'd2,
        CONVERT       = 3'd3,
        ROUND         = 3'd4,
        PUT_Z         = 3'd5
    } fpu_state_t;

endpackage

// File: rtl/float_to_int_if.sv
// Operand/result stb-ack handshake bundle shared by the FPU converters.
// master = producer/consumer side, slave = converter side.
interface float_to_int_if;

    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    modport master (
        output input_a, input_a_stb, output_z_ack,
        input  input_a_ack, output_z, output_z_stb
    );

    modport slave (
        input  input_a, input_a_stb, output_z_ack,
        output input_a_ack, output_z, output_z_stb
    );

endinterface

// File: rtl/float_unpack_sp.sv
// Combinational split of an IEEE single into sign, biased exponent and
// mantissa with the implicit leading one restored (zero for denormals).
module float_unpack_sp
    import fpu_pkg::*;
(
    input  logic [31:0]      a,
    output logic             sign,
    output logic [EXP_W-1:0] exp_b,
    output logic [MANT_W:0]  mant
);

    assign sign  = a[SIGN_POS];
    assign exp_b = a[EXP_HI:EXP_LO];
    assign mant  = {(exp_b != '0), a[MANT_HI:0]};

endmodule

// File: rtl/float_to_int.sv
// Iterative single -> int32 converter, truncating toward zero by default;
// FLOAT_TO_INT_ROUND_NEAREST_EN selects round-to-nearest-even instead.
module float_to_int
    import fpu_pkg::*;
(
    input logic           clk,
    input logic           rst,
    float_to_int_if.slave bus
);

    fpu_state_t state_q, state_d;

    logic [31:0]       a_q, a_d;
    logic [31:0]       m_q, m_d;
    logic [31:0]       z_q, z_d;
    logic [31:0]       out_q, out_d;
    logic signed [9:0] e_q, e_d;
    logic              s_q, s_d;
    logic              ack_q, ack_d;
    logic              stb_q, stb_d;

    logic              u_sign;
    logic [EXP_W-1:0]  u_exp;
    logic [MANT_W:0]   u_mant;

`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
    logic              guard_q, guard_d;
    logic              sticky_q, sticky_d;
    logic [31:0]       m_rnd;

    assign m_rnd = m_q + {31'b0, guard_q & (sticky_q | m_q[0])};
`endif

    float_unpack_sp u_unpack (
        .a     (a_q),
        .sign  (u_sign),
        .exp_b (u_exp),
        .mant  (u_mant)
    );

    assign bus.input_a_ack  = ack_q;
    assign bus.output_z_stb = stb_q;
    assign bus.output_z     = out_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        z_d     = z_q;
        out_d   = out_q;
        e_d     = e_q;
        s_d     = s_q;
        ack_d   = ack_q;
        stb_d   = stb_q;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
        guard_d  = guard_q;
        sticky_d = sticky_q;
`endif
        unique case (state_q)
            GET_A: begin
                ack_d = 1'b1;
                if (ack_q && bus.input_a_stb) begin
                    a_d     = bus.input_a;
                    ack_d   = 1'b0;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                m_d     = {u_mant, 8'b0};
                e_d     = signed'({2'b0, u_exp} - BIAS_SP);
                s_d     = u_sign;
                state_d = SPECIAL_CASES;
            end
            SPECIAL_CASES: begin
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
                guard_d  = 1'b0;
                sticky_d = 1'b0;
`endif
                // Anything at or above 2^31, plus Inf/NaN, saturates to INT_MIN
                if (a_q[EXP_HI:EXP_LO] == EXP_SP_MAX || e_q >= 10'sd31) begin
                    z_d     = INT32_MIN;
                    state_d = PUT_Z;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
                end else if (e_q < -10'sd1) begin
`else
                end else if (e_q < 10'sd0) begin
`endif
                    z_d     = '0;
                    state_d = PUT_Z;
                end else begin
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                if (e_q < 10'sd31) begin
                    m_d = m_q >> 1;
                    e_d = e_q + 10'sd1;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
                    guard_d  = m_q[0];
                    sticky_d = sticky_q | guard_q;
`endif
                end else begin
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
                    state_d = ROUND;
`else
                    z_d     = s_q ? -m_q : m_q;
                    state_d = PUT_Z;
`endif
                end
            end
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
            ROUND: begin
                z_d     = s_q ? -m_rnd : m_rnd;
                state_d = PUT_Z;
            end
`endif
            PUT_Z: begin
                stb_d = 1'b1;
                out_d = z_q;
                if (stb_q && bus.output_z_ack) begin
                    stb_d   = 1'b0;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= GET_A;
            a_q     <= '0;
            m_q     <= '0;
            z_q     <= '0;
            out_q   <= '0;
            e_q     <= '0;
            s_q     <= 1'b0;
            ack_q   <= 1'b0;
            stb_q   <= 1'b0;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            z_q     <= z_d;
            out_q   <= out_d;
            e_q     <= e_d;
            s_q     <= s_d;
            ack_q   <= ack_d;
            stb_q   <= stb_d;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
`endif
        end
    end

endmodule

// File: tb/tb_float_to_int.sv
// Directed and back-to-back random checks of float_to_int, truncating or
// nearest-even depending on FLOAT_TO_INT_ROUND_NEAREST_EN.
module tb_float_to_int;

`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
    localparam bit RN = 1'b1;
`else
    localparam bit RN = 1'b0;
`endif
    localparam int RL = RN ? 1 : 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    float_to_int_if bus ();

    float_to_int dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a);
        int          e;
        int          sh;
        logic [63:0] mag, q, rem, half;
        logic        inc;
        e = int'(a[30:23]) - 127;
        if (a[30:23] == 8'hFF || e >= 31) return 32'h80000000;
        mag = {40'b0, 1'b1, a[22:0]};
        if (e >= 23) begin
            q = mag << (e - 23);
        end else begin
            sh = 23 - e;
            if (sh > 40) sh = 40;
            q    = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            inc  = RN && ((rem > half) || (rem == half && q[0]));
            q    = q + {63'b0, inc};
        end
        return a[31] ? -q[31:0] : q[31:0];
    endfunction

    // Called #1 after an edge; holds the result `hold` cycles before acking
    task automatic xfer(input logic [31:0] a, input logic [31:0] ez,
                        input int elat, input int hold, input string tag);
        int w;
        int lat;
        logic [31:0] zs;
        bus.input_a     = a;
        bus.input_a_stb = 1'b1;
        w = 0;
        while (bus.input_a_ack !== 1'b1 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk({tag, "_accept"}, {31'b0, bus.input_a_ack}, 32'd1);
        @(posedge clk); #1;
        bus.input_a_stb = 1'b0;
        lat = 0;
        while (bus.output_z_stb !== 1'b1 && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_z"}, bus.output_z, ez);
        zs = bus.output_z;
        bus.input_a     = 32'h3F800000;
        bus.input_a_stb = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_z"}, bus.output_z, zs);
            chk({tag, "_hold_stb"}, {31'b0, bus.output_z_stb}, 32'd1);
            chk({tag, "_no_reaccept"}, {31'b0, bus.input_a_ack}, 32'd0);
        end
        bus.input_a_stb  = 1'b0;
        bus.output_z_ack = 1'b1;
        @(posedge clk); #1;
        bus.output_z_ack = 1'b0;
        chk({tag, "_stb_drop"}, {31'b0, bus.output_z_stb}, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] r;
        logic [7:0]  ex;
        int          got;
        int          cyc;
        int          n_stb;
        int          w;
        bit          took;

        bus.input_a      = '0;
        bus.input_a_stb  = 1'b0;
        bus.output_z_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'b0, bus.input_a_ack}, 32'd0);
        chk("rst_stb", {31'b0, bus.output_z_stb}, 32'd0);
        chk("rst_z", bus.output_z, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        xfer(32'h3F800000, 32'h00000001, 35 + RL, 0, "one");
        xfer(32'hC2F6E666, 32'hFFFFFF85, 29 + RL, 5, "m123_45");
        xfer(32'h7F800000, 32'h80000000, 3, 0, "pinf");
        xfer(32'h7FC00000, 32'h80000000, 3, 0, "nan");
        xfer(32'h4F000000, 32'h80000000, 3, 0, "p2_31");
        xfer(32'hCF000000, 32'h80000000, 3, 0, "m2_31");
        xfer(32'h00000000, 32'h00000000, 3, 0, "zero");
        xfer(32'h3F000000, 32'h00000000, RN ? 37 : 3, 0, "half");
        xfer(32'h40200000, 32'h00000002, 34 + RL, 0, "p2_5");
        xfer(32'h40600000, RN ? 32'h4 : 32'h3, 34 + RL, 0, "p3_5");
        xfer(32'h3F400000, RN ? 32'h1 : 32'h0, RN ? 37 : 3, 0, "p0_75");
        xfer(32'hBFC00000, RN ? 32'hFFFFFFFE : 32'hFFFFFFFF, 35 + RL, 0,
             "m1_5");

        // Async reset in the middle of a long conversion
        bus.input_a     = 32'h3F800000;
        bus.input_a_stb = 1'b1;
        w = 0;
        while (bus.input_a_ack !== 1'b1 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        bus.input_a_stb = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_ack", {31'b0, bus.input_a_ack}, 32'd0);
        chk("arst_stb", {31'b0, bus.output_z_stb}, 32'd0);
        chk("arst_z", bus.output_z, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.output_z_ack = 1'b1;
        n_stb = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.output_z_stb === 1'b1) n_stb++;
        end
        bus.output_z_ack = 1'b0;
        chk("arst_no_output", n_stb, 0);
        xfer(32'h4B000001, 32'h00800001, 12 + RL, 0, "p8388609");

        // Back-to-back: stb held high, ack tied high
        bus.output_z_ack = 1'b1;
        got = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    r  = $urandom;
                    ex = (i % 4 != 0) ? 8'($urandom_range(120, 160)) : r[30:23];
                    bus.input_a     = {r[31], ex, r[22:0]};
                    bus.input_a_stb = 1'b1;
                    w    = 0;
                    took = 1'b0;
                    while (!took && w < 200) begin
                        @(negedge clk);
                        took = (bus.input_a_ack === 1'b1);
                        @(posedge clk);
                        w++;
                    end
                    if (!took) break;
                    exp_q.push_back(model(bus.input_a));
                    #1;
                end
                bus.input_a_stb = 1'b0;
            end
            begin
                cyc = 0;
                while (got < 1000 && cyc < 60000) begin
                    @(negedge clk);
                    cyc++;
                    if (bus.output_z_stb === 1'b1) begin
                        if (exp_q.size() > 0)
                            chk("rand_z", bus.output_z, exp_q.pop_front());
                        else
                            chk("rand_extra", bus.output_z_stb, 32'd0);
                        got++;
                    end
                end
            end
        join
        bus.output_z_ack = 1'b0;
        chk("rand_count", got, 1000);
        chk("rand_pending", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/float_to_int.md
Name: float_to_int

Overview:
- Converts an IEEE-754 single-precision value to a signed 32-bit two's-complement integer.
- Default rounding is toward zero, matching a C cast.
- Inverse companion of the integer-to-float converter; shares its ack/stb handshake so the two chain or swap freely in the FPU.
- Iterative, one-bit-per-cycle shifter; small area, variable latency.

Parameters:
None. Fixed single precision in, 32-bit signed out.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
input_a  input  32  IEEE single operand
input_a_stb  input  1  producer asserts: operand valid
input_a_ack  output  1  block ready to accept operand
output_z  output  32  signed integer result
output_z_stb  output  1  result valid
output_z_ack  input  1  consumer accepts result

Behaviour:
- Reset (async, active-high):
  - state=get_a.
  - input_a_ack=0, output_z_stb=0, output_z=0.
  - Internal registers don't-care.
  - Reset mid-operation abandons the operand; no output is produced for it.
- States: get_a, unpack, special_cases, convert, [round], put_z.
- get_a:
  - Drive ack<=1.
  - Transfer occurs on an edge where ack&&stb.
  - On transfer: latch a, ack<=0, go to unpack.
- unpack:
  - m = {1'b1, a[22:0], 8'b0} (32 bits).
  - e = a[30:23] - 127 (10-bit signed).
  - s = a[31].
  - Go to special_cases.
- special_cases:
  - e==128 (Inf/NaN) or e>=31: z=32'h80000000, go to put_z. This includes exactly -2^31.
  - e<0: z=0, go to put_z. Denormals and ±0 land here.
  - Otherwise go to convert.
- convert:
  - While e<31: m<=m>>1, e<=e+1.
  - Shifted-out bits feed guard/round/sticky: guard = last bit out; sticky = OR of all earlier bits.
  - When e==31: z = s ? -m : m, go to put_z.
- put_z:
  - output_z_stb<=1, output_z<=z.
  - On an edge with stb&&output_z_ack: stb<=0, go to get_a.
  - output_z holds stable while stb is high.
  - The consumer may hold ack high continuously.
- Latency, counted in edges from the accept edge to stb high:
  - Special cases: 3.
  - Normal: 4+(31-e), i.e. 5..35.
- No pipelining; one operand in flight. input_a_ack stays low from accept until return to get_a.

Optional Feature:
Macro FLOAT_TO_INT_ROUND_NEAREST_EN.
- Defined:
  - Round-to-nearest-even replaces truncation.
  - special_cases sends e==-1 to convert, not zero.
  - convert exits to a round state: increment m when guard && (sticky || m[0]), then apply sign, then go to put_z.
  - Normal latency +1.
  - Rounding cannot overflow: the largest float below 2^31 is an exact integer.
- Undefined: truncation toward zero; no round state; guard/sticky logic absent.

Decomposition:
- Shared package fpu_pkg:
  - State encodings (3-bit).
  - BIAS_SP=127.
  - EXP_SP_MAX=8'hFF.
  - INT32_MIN=32'h80000000.
  - Field-position constants, also used by the integer-to-float converter.
- One natural sub-module, float_unpack_sp: combinational split of a single into sign/biased exponent/mantissa with implicit one. Reusable across the FPU.

Test Plan:
- 32'h3F800000 (1.0) -> 32'h00000001, stb high exactly 35 edges after accept. Tests max-shift latency.
- 32'hC2F6E666 (-123.45) -> 32'hFFFFFF85 (-123); consumer holds ack low 5 cycles -> output_z stable, no re-accept until ack.
- Specials:
  - 32'h7F800000 (+Inf) -> 32'h80000000.
  - 32'h7FC00000 (NaN) -> 32'h80000000.
  - 32'h4F000000 (2^31) -> 32'h80000000.
  - 32'hCF000000 (-2^31) -> 32'h80000000.
  - 32'h00000000 -> 0.
  - 32'h3F000000 (0.5) -> 0.
  - Special latency 3 edges.
- With FLOAT_TO_INT_ROUND_NEAREST_EN:
  - 32'h40200000 (2.5) -> 2.
  - 32'h40600000 (3.5) -> 4.
  - 32'h3F400000 (0.75) -> 1.
  - 32'hBFC00000 (-1.5) -> 32'hFFFFFFFE.
- Assert rst asynchronously mid-convert -> ack/stb drop immediately, no output. Next operand 32'h4B000001 (8388609.0) -> 32'h00800001.
- Back-to-back: 1000 random floats with stb held high and ack tied high. Compare against a truncating reference model, or a nearest-even one when the macro is defined. No lost or duplicated transfers.
